// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int num_digits(input int width, input int digit_w);
    return width / digit_w;
  endfunction

  // Index counter needs at least one bit even when there is a single digit.
  function automatic int idx_width(input int n_digits);
    return (n_digits > 1) ? $clog2(n_digits) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// Combinational ripple of DIGIT_W full-adder cells; exposes the carry into the
// top bit so the caller can derive signed overflow on the final digit.
module digit_adder #(
  parameter int DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               c_in,
  output logic [DIGIT_W-1:0] sum,
  output logic               c_out,
  output logic               c_msb_in
);

  always_comb begin
    logic carry;
    sum      = '0;
    c_msb_in = c_in;
    carry    = c_in;
    for (int i = 0; i < DIGIT_W; i++) begin
      if (i == DIGIT_W - 1) c_msb_in = carry;
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    c_out = carry;
  end

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder with valid/ready handshakes on both sides.
// Optional subtract mode is built when SERIAL_ADDER_SUB_EN is defined.
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   RUN   | adding one digit per cycle, low digit first
//   DONE  | result held, out_valid high until out_ready
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DIGIT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NUM_DIGITS = num_digits(WIDTH, DIGIT_W);
  localparam int IDX_W      = idx_width(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  if ((WIDTH % DIGIT_W) != 0) begin : g_bad_width
    $error("serial_adder: WIDTH (%0d) must be a multiple of DIGIT_W (%0d)", WIDTH, DIGIT_W);
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry_q;
  logic             accept, last_digit;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  logic [DIGIT_W-1:0] dig_sum;
  logic               dig_cout, dig_cmsb;

  // Subtraction folds into the operand capture: store ~b and force carry-in.
`ifdef SERIAL_ADDER_SUB_EN
  always_comb begin
    b_eff   = sub ? ~b : b;
    cin_eff = sub ? 1'b1 : c_in;
  end
`else
  always_comb begin
    b_eff   = b;
    cin_eff = c_in;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (last_digit) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept     = in_valid & in_ready;
  assign last_digit = (idx_q == LAST_IDX);

  digit_adder #(.DIGIT_W(DIGIT_W)) u_digit (
    .a        (a_q[idx_q*DIGIT_W +: DIGIT_W]),
    .b        (b_q[idx_q*DIGIT_W +: DIGIT_W]),
    .c_in     (carry_q),
    .sum      (dig_sum),
    .c_out    (dig_cout),
    .c_msb_in (dig_cmsb)
  );

  // carry_q is loaded with the carry-in at accept, so digit 0 needs no special case.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum     <= '0;
      c_out   <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b_eff;
      carry_q <= cin_eff;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      sum[idx_q*DIGIT_W +: DIGIT_W] <= dig_sum;
      carry_q <= dig_cout;
      if (last_digit) begin
        idx_q <= '0;
        c_out <= dig_cout;
        ovf   <= dig_cmsb ^ dig_cout;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus randomized operations
// with random result backpressure, checked against an arithmetic reference model.
module tb_serial_adder;

  localparam int WIDTH   = 16;
  localparam int DIGIT_W = 4;
  localparam int ND      = WIDTH / DIGIT_W;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, c_in, out_valid, out_ready, c_out, ovf, sub;
  logic [WIDTH-1:0] a, b, sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(WIDTH), .DIGIT_W(DIGIT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: returns {ovf, c_out, sum} from integer arithmetic.
  function automatic logic [WIDTH+1:0] ref_op(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                                              input logic rc, input logic rs);
    longint ua, ub, sa, sb, full, sres, lo, hi;
    logic   co, ov;
    ua = longint'(ra);
    ub = longint'(rb);
    sa = longint'($signed(ra));
    sb = longint'($signed(rb));
    lo = -(longint'(1) << (WIDTH - 1));
    hi = (longint'(1) << (WIDTH - 1)) - 1;
    if (rs) begin
      full = ua - ub;
      co   = (ua >= ub);
      sres = sa - sb;
    end else begin
      full = ua + ub + longint'(rc);
      co   = (full >= (longint'(1) << WIDTH));
      sres = sa + sb + longint'(rc);
    end
    ov = (sres < lo) || (sres > hi);
    return {ov, co, full[WIDTH-1:0]};
  endfunction

  // Called #1 after a rising edge; leaves the block back in IDLE, #1 after an edge.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic tc,
                        input logic ts, input int bp, input string tag);
    logic [WIDTH+1:0] e;
    int n;
    e = ref_op(ta, tb_, tc, ts);
    a = ta; b = tb_; c_in = tc; sub = ts; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_latency"}, n, ND);
    chk({tag, "_sum"}, {16'd0, sum}, {16'd0, e[WIDTH-1:0]});
    chk({tag, "_c_out"}, {31'd0, c_out}, {31'd0, e[WIDTH]});
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, e[WIDTH+1]});
    for (int i = 0; i < bp; i++) begin
      in_valid = 1'($urandom); a = WIDTH'($urandom); b = WIDTH'($urandom);
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
      chk({tag, "_hold_res"}, {14'd0, ovf, c_out, sum}, {14'd0, e});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_idle_keep"}, {16'd0, sum}, {16'd0, e[WIDTH-1:0]});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_c_out", {31'd0, c_out}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    rst = 1'b0;

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, "basic");
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, "wrap");
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, "ovf");
    run_op(16'h00FF, 16'h0000, 1'b1, 1'b0, 0, "cin");
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 5, "backpressure");

    // Reset while the third digit is about to be added.
    a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_sum", {16'd0, sum}, 32'd0);
    for (int i = 0; i < ND + 2; i++) begin
      @(posedge clk); #1;
      chk("midrst_quiet", {31'd0, out_valid}, 32'd0);
    end
    run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 0, "post_rst");

`ifdef SERIAL_ADDER_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, "sub_borrow");
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, "sub_ovf");
`endif

    for (int k = 0; k < 2000; k++) begin
      logic rs;
      rs = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
`endif
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), rs, int'($urandom_range(0, 3)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
